double_to_integer_scheduler: RTL
================================

DOUBLE_TO_INTEGER_SCHEDULER -- requirements
Module: double_to_integer_scheduler

Interface
REQ-001 SHALL have parameter: TAG_WIDTH, 4, width of requester transaction tag.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports, per requester k in {0,1}: req_valid_k  input  1  request present; req_ready_k  output  1  request accepted this cycle; req_double_k  input  64  IEEE-754 double operand (sign, exponent[62:52], mantissa[51:0]); req_sign_mode_k  input  1  1 = signed result, 0 = unsigned; req_tag_k  input  TAG_WIDTH  requester tag.
REQ-005 SHALL have converter-side ports: cvt_input_double  output  64  operand to shared combinational converter; cvt_sign_mode  output  1  mode to converter; cvt_converted_integer  input  32  converter result.
REQ-006 SHALL have response ports: resp_valid  output  1; resp_ready  input  1; resp_integer  output  32; resp_tag  output  TAG_WIDTH; resp_port  output  1  index of originating requester; resp_invalid  output  1  invalid-operation flag.

Function
REQ-007 SHALL implement FSM states IDLE, CONVERT, RESPOND; one transaction in flight at a time.
REQ-008 SHALL, in IDLE, assert req_ready_k combinationally only for the granted requester k and only when req_valid_k is high; never both ready in one cycle.
REQ-009 SHALL grant round-robin: single valid requester wins; both valid -> requester named by priority pointer wins.
REQ-010 SHALL, after each accepted request from port k, set the priority pointer to port 1-k.
REQ-011 SHALL, on accept, latch operand, sign_mode, tag, and port index into an operand register, then go IDLE -> CONVERT.
REQ-012 SHALL drive cvt_input_double/cvt_sign_mode from the operand register at all times (zero after reset until first accept).
REQ-013 SHALL, in CONVERT, capture cvt_converted_integer into resp_integer register and go to RESPOND.
REQ-014 SHALL, in RESPOND, hold resp_valid high with resp_integer, resp_tag, resp_port, resp_invalid stable until resp_ready is high; on handshake go to IDLE.
REQ-015 SHALL have latency: accept at cycle N -> resp_valid at N+2; best-case throughput one transaction per 3 cycles.
REQ-016 SHALL ignore req_valid in CONVERT and RESPOND (req_ready low); request inputs need not be held after acceptance.
REQ-017 SHALL keep resp_valid low in IDLE and CONVERT; response registers may hold stale values while resp_valid is low.
REQ-018 SHALL not alter resp_* while resp_valid is high and resp_ready is low (backpressure of any length).

Reset
REQ-019 SHALL, with reset high at a rising edge, force state IDLE, priority pointer to port 0, resp_valid 0, resp_integer 0, resp_tag 0, resp_port 0, resp_invalid 0, operand register 0.
REQ-020 SHALL, on reset mid-transaction (CONVERT or RESPOND), discard the transaction with no response; req_ready low during reset cycle.

Configuration
REQ-021 SHALL, with macro DRAGONFANG_FCVT_INVALID_FLAG_EN defined, compute resp_invalid in CONVERT from the latched operand: exponent == 2047; or signed and exponent >= 1054; or unsigned and exponent >= 1055; or unsigned, sign = 1 and exponent >= 1023.
REQ-022 SHALL, without DRAGONFANG_FCVT_INVALID_FLAG_EN, tie resp_invalid to 0 and include no flag logic; all other behaviour is identical.

Verification
REQ-023 SHALL cover: port 0 sends 0x3FF0000000000000, signed, tag 3, bench converter returns 1 -> resp_valid two cycles after accept, resp_integer 1, resp_tag 3, resp_port 0.
REQ-024 SHALL cover: both ports valid continuously after reset -> grants in order 0,1,0,1; never both req_ready high.
REQ-025 SHALL cover: resp_ready held low 5 cycles in RESPOND -> resp_* constant, req_ready_0/1 low, single handshake on sixth cycle, then IDLE.
REQ-026 SHALL cover: reset asserted in CONVERT -> next cycle resp_valid 0, state IDLE, pointer 0, no response for that tag.
REQ-027 SHALL cover, with macro: unsigned 0xBFF0000000000000 (-1.0) -> resp_invalid 1; signed 0x41E0000000000000 (2^31) -> resp_invalid 1; signed 0x41DFFFFFFFC00000 (2^31-1) -> resp_invalid 0; without macro all -> resp_invalid 0.

Source files
------------

// File: rtl/double_to_integer_scheduler.sv
// double_to_integer_scheduler
//   Arbitrates two requesters onto one shared combinational double-to-integer
//   converter. Only one transaction is in flight at a time:
//     IDLE    : grant one requester round-robin and latch its operand
//     CONVERT : capture the converter result (and optional invalid flag)
//     RESPOND : present the response until the consumer accepts it
//
// Optional feature macro: DRAGONFANG_FCVT_INVALID_FLAG_EN
//   When defined, resp_invalid reports operands that cannot be represented in
//   the requested integer format. When undefined, resp_invalid is tied to 0.
//
// Ports
//   clock, reset                  : single clock, synchronous active-high reset
//   req_valid_k / req_ready_k     : request handshake for requester k (0/1)
//   req_double_k                  : IEEE-754 double operand
//   req_sign_mode_k               : 1 = signed result, 0 = unsigned
//   req_tag_k                     : requester tag, returned with the response
//   cvt_input_double, cvt_sign_mode : operand/mode to the shared converter
//   cvt_converted_integer         : converter result
//   resp_valid / resp_ready       : response handshake
//   resp_integer, resp_tag, resp_port, resp_invalid : response payload
module double_to_integer_scheduler #(
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,

  input  logic                 req_valid_0,
  output logic                 req_ready_0,
  input  logic [63:0]          req_double_0,
  input  logic                 req_sign_mode_0,
  input  logic [TAG_WIDTH-1:0] req_tag_0,

  input  logic                 req_valid_1,
  output logic                 req_ready_1,
  input  logic [63:0]          req_double_1,
  input  logic                 req_sign_mode_1,
  input  logic [TAG_WIDTH-1:0] req_tag_1,

  output logic [63:0]          cvt_input_double,
  output logic                 cvt_sign_mode,
  input  logic [31:0]          cvt_converted_integer,

  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_integer,
  output logic [TAG_WIDTH-1:0] resp_tag,
  output logic                 resp_port,
  output logic                 resp_invalid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 ptr_q, ptr_d;

  logic [63:0]          op_double_q, op_double_d;
  logic                 op_sign_q, op_sign_d;
  logic [TAG_WIDTH-1:0] op_tag_q, op_tag_d;
  logic                 op_port_q, op_port_d;

  logic [31:0]          resp_int_q, resp_int_d;
  logic [TAG_WIDTH-1:0] resp_tag_q, resp_tag_d;
  logic                 resp_port_q, resp_port_d;

  logic                 grant_0, grant_1;

  // A lone valid requester always wins; on contention the pointer decides.
  assign grant_0 = req_valid_0 && (!req_valid_1 || !ptr_q);
  assign grant_1 = req_valid_1 && (!req_valid_0 ||  ptr_q);

  // Ready is suppressed during reset so nothing is accepted on that edge.
  assign req_ready_0 = (state_q == IDLE) && !reset && grant_0;
  assign req_ready_1 = (state_q == IDLE) && !reset && grant_1;

  assign cvt_input_double = op_double_q;
  assign cvt_sign_mode    = op_sign_q;

  assign resp_valid   = (state_q == RESPOND);
  assign resp_integer = resp_int_q;
  assign resp_tag     = resp_tag_q;
  assign resp_port    = resp_port_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_double_d = op_double_q;
    op_sign_d   = op_sign_q;
    op_tag_d    = op_tag_q;
    op_port_d   = op_port_q;
    resp_int_d  = resp_int_q;
    resp_tag_d  = resp_tag_q;
    resp_port_d = resp_port_q;

    case (state_q)
      // Accept: latch the granted operand and hand priority to the other port.
      IDLE: begin
        if (req_ready_0) begin
          op_double_d = req_double_0;
          op_sign_d   = req_sign_mode_0;
          op_tag_d    = req_tag_0;
          op_port_d   = 1'b0;
          ptr_d       = 1'b1;
          state_d     = CONVERT;
        end else if (req_ready_1) begin
          op_double_d = req_double_1;
          op_sign_d   = req_sign_mode_1;
          op_tag_d    = req_tag_1;
          op_port_d   = 1'b1;
          ptr_d       = 1'b0;
          state_d     = CONVERT;
        end
      end
      // Convert: the converter has had a full cycle on the latched operand.
      CONVERT: begin
        resp_int_d  = cvt_converted_integer;
        resp_tag_d  = op_tag_q;
        resp_port_d = op_port_q;
        state_d     = RESPOND;
      end
      // Respond: payload registers are only written in CONVERT, so they
      // stay frozen for any length of backpressure.
      RESPOND: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      op_double_q <= '0;
      op_sign_q   <= 1'b0;
      op_tag_q    <= '0;
      op_port_q   <= 1'b0;
      resp_int_q  <= '0;
      resp_tag_q  <= '0;
      resp_port_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_double_q <= op_double_d;
      op_sign_q   <= op_sign_d;
      op_tag_q    <= op_tag_d;
      op_port_q   <= op_port_d;
      resp_int_q  <= resp_int_d;
      resp_tag_q  <= resp_tag_d;
      resp_port_q <= resp_port_d;
    end
  end

`ifdef DRAGONFANG_FCVT_INVALID_FLAG_EN
  logic resp_inv_q, resp_inv_d;

  // Exponent thresholds: 1054 is 2^31 (signed overflow), 1055 is 2^32
  // (unsigned overflow), 1023 is magnitude >= 1.0 (negative unsigned).
  // Exponent 2047 covers infinities and NaNs.
  function automatic logic fcvt_invalid(input logic [63:0] d, input logic signed_mode);
    logic [10:0] e;
    e = d[62:52];
    return (e == 11'd2047)
        || ( signed_mode && (e >= 11'd1054))
        || (!signed_mode && (e >= 11'd1055))
        || (!signed_mode && d[63] && (e >= 11'd1023));
  endfunction

  always_comb begin
    resp_inv_d = resp_inv_q;
    if (state_q == CONVERT) resp_inv_d = fcvt_invalid(op_double_q, op_sign_q);
  end

  always_ff @(posedge clock) begin
    if (reset) resp_inv_q <= 1'b0;
    else       resp_inv_q <= resp_inv_d;
  end

  assign resp_invalid = resp_inv_q;
`else
  assign resp_invalid = 1'b0;
`endif

endmodule
